bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown.sv | 143 ++++++++++++++
 tb/tb_bcd_countdown.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// bcd_countdown: mm:ss BCD countdown timer driven by a 1 Hz tick derived from clk_1.
//
// Ports:
//   clk      in   system clock, the only clock
//   rst      in   synchronous active-high reset
//   clk_1    in   1 Hz square wave in the clk domain; each rising edge is one second
//   load     in   one-cycle strobe: load min_in/sec_in (outside RUN, if valid)
//   min_in   in   BCD minutes {tens,units}
//   sec_in   in   BCD seconds {tens,units}
//   start    in   one-cycle strobe: start/resume from IDLE or PAUSE
//   pause    in   one-cycle strobe: halt a running countdown
//   min_out  out  current BCD minutes
//   sec_out  out  current BCD seconds
//   running  out  high while in RUN
//   done     out  one-cycle pulse when the count reaches 00:00
//   alarm    out  high while in ALARM
module bcd_countdown #(
    parameter logic [7:0] MAX_MIN = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1,
    input  logic       load,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BYTE_W  = 2 * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   min_q, min_d;
    logic [BYTE_W-1:0]   sec_q, sec_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                alarm_q, alarm_d;
    logic                clk_1_d;

    logic                tick_c;
    logic                load_ok_c;
    logic                is_zero_c;
    logic                last_sec_c;
    logic [BYTE_W-1:0]   dec_min_c;
    logic [BYTE_W-1:0]   dec_sec_c;

    // Rising-edge detect on clk_1; clk_1_d resets high so a high clk_1 after reset is not a tick.
    assign tick_c = clk_1 & ~clk_1_d;

    // Load operand check: BCD digits, seconds tens below 6, minutes within range.
    assign load_ok_c = (min_in[7:4] <= DIGIT_W'(9)) && (min_in[3:0] <= DIGIT_W'(9))
                    && (sec_in[7:4] <= DIGIT_W'(5)) && (sec_in[3:0] <= DIGIT_W'(9))
                    && (min_in <= MAX_MIN);

    assign is_zero_c  = (min_q == BYTE_W'(0)) && (sec_q == BYTE_W'(0));
    assign last_sec_c = (min_q == BYTE_W'(0)) && (sec_q == BYTE_W'(8'h01));

    // One-second BCD decrement with borrow chain sec units -> sec tens -> minutes.
    always_comb begin
        dec_min_c = min_q;
        dec_sec_c = sec_q;
        if (sec_q[3:0] != DIGIT_W'(0)) begin
            dec_sec_c[3:0] = sec_q[3:0] - DIGIT_W'(1);
        end else if (sec_q[7:4] != DIGIT_W'(0)) begin
            dec_sec_c = {sec_q[7:4] - DIGIT_W'(1), DIGIT_W'(9)};
        end else begin
            dec_sec_c = BYTE_W'(8'h59);
            if (min_q[3:0] != DIGIT_W'(0)) begin
                dec_min_c[3:0] = min_q[3:0] - DIGIT_W'(1);
            end else begin
                dec_min_c = {min_q[7:4] - DIGIT_W'(1), DIGIT_W'(9)};
            end
        end
    end

    // Next state and outputs; priority load > pause > start > tick.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;

        if (load && load_ok_c && (state_q != ST_RUN)) begin
            min_d   = min_in;
            sec_d   = sec_in;
            state_d = ST_IDLE;
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) && !is_zero_c) begin
            state_d = ST_RUN;
        end else if (tick_c && (state_q == ST_RUN)) begin
            min_d = dec_min_c;
            sec_d = dec_sec_c;
            if (last_sec_c) begin
                state_d = ST_ALARM;
                done_d  = 1'b1;
            end
        end

        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            min_q     <= BYTE_W'(0);
            sec_q     <= BYTE_W'(0);
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            clk_1_d   <= 1'b1;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
            clk_1_d   <= clk_1;
        end
    end

    assign min_out = min_q;
    assign sec_out = sec_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed and random stimulus for bcd_countdown, checked every cycle
// against a reference model that keeps the remaining time as plain integer seconds.
module tb_bcd_countdown;

    localparam logic [7:0] MAX_MIN = 8'h59;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1 = 1'b1;
    logic       load = 1'b0;
    logic [7:0] min_in = 8'h00;
    logic [7:0] sec_in = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       done;
    logic       alarm;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int m_secs = 0;
    int m_mode = M_IDLE;
    bit m_done = 1'b0;
    bit m_prev = 1'b1;

    always #5 clk = ~clk;

    bcd_countdown #(.MAX_MIN(MAX_MIN)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_1   (clk_1),
        .load    (load),
        .min_in  (min_in),
        .sec_in  (sec_in),
        .start   (start),
        .pause   (pause),
        .min_out (min_out),
        .sec_out (sec_out),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit load_valid(input logic [7:0] mi, input logic [7:0] se);
        return (mi[7:4] <= 4'd9) && (mi[3:0] <= 4'd9) && (se[7:4] <= 4'd5)
            && (se[3:0] <= 4'd9) && (mi <= MAX_MIN);
    endfunction

    // Advance the model by one clk edge using the inputs currently applied.
    task automatic model_update();
        bit tick;
        if (rst) begin
            m_secs = 0;
            m_mode = M_IDLE;
            m_done = 1'b0;
            m_prev = 1'b1;
            return;
        end
        tick   = clk_1 && !m_prev;
        m_prev = clk_1;
        m_done = 1'b0;
        if (load && load_valid(min_in, sec_in) && m_mode != M_RUN) begin
            m_secs = bcd2int(min_in) * 60 + bcd2int(sec_in);
            m_mode = M_IDLE;
        end else if (pause && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs != 0) begin
            m_mode = M_RUN;
        end else if (tick && m_mode == M_RUN) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_mode = M_ALARM;
                m_done = 1'b1;
            end
        end
    endtask

    // One clk cycle: update the model, clock the DUT, compare all outputs.
    task automatic step();
        logic [18:0] exp_v;
        logic [18:0] obs_v;
        model_update();
        @(posedge clk);
        #1;
        exp_v = {int2bcd(m_secs / 60), int2bcd(m_secs % 60),
                 (m_mode == M_RUN), (m_mode == M_ALARM), m_done};
        obs_v = {min_out, sec_out, running, alarm, done};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_mis++;
            $error("FAIL model t=%0t: observed %h:%h run=%b alm=%b done=%b expected %h:%h run=%b alm=%b done=%b",
                   $time, obs_v[18:11], obs_v[10:3], obs_v[2], obs_v[1], obs_v[0],
                   exp_v[18:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Directed check of the current outputs against literal expectations.
    task automatic expect_v(input string tag, input logic [7:0] m, input logic [7:0] s,
                            input logic r, input logic a, input logic d);
        n_cmp++;
        assert ({min_out, sec_out, running, alarm, done} === {m, s, r, a, d}) else begin
            n_mis++;
            $error("FAIL %s: observed %h:%h run=%b alm=%b done=%b expected %h:%h run=%b alm=%b done=%b",
                   tag, min_out, sec_out, running, alarm, done, m, s, r, a, d);
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; min_in = m; sec_in = s;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Rising edge of clk_1: the step observes the result of the tick.
    task automatic rise();
        clk_1 = 1'b1;
        step();
    endtask

    // Rest of the 1 Hz period: high one more cycle, then low two cycles.
    task automatic fall();
        step();
        clk_1 = 1'b0;
        step();
        step();
    endtask

    task automatic second();
        rise();
        fall();
    endtask

    initial begin
        int half;
        int cnt;

        // Reset with clk_1 held high, then release with clk_1 still high
        rst = 1'b1; clk_1 = 1'b1;
        step();
        step();
        expect_v("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        step();
        step();
        expect_v("post_reset_no_tick", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        clk_1 = 1'b0;
        step();

        // Start at 00:00 is ignored
        do_start();
        expect_v("start_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // 01:00 countdown to alarm
        do_load(8'h01, 8'h00);
        expect_v("load_0100", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        do_start();
        expect_v("start_0100", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        rise();
        expect_v("tick_0059", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
        fall();
        for (int i = 0; i < 58; i++) second();
        expect_v("at_0001", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        rise();
        expect_v("done_pulse", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        expect_v("done_cleared", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        fall();

        // ALARM: start ignored, then valid load clears alarm
        do_start();
        expect_v("alarm_start_ign", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        do_load(8'h00, 8'h05);
        expect_v("alarm_load", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);

        // Invalid loads leave the value and state alone
        do_load(8'h00, 8'h60);
        expect_v("inv_sec60", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        do_load(8'h00, 8'h0A);
        expect_v("inv_sec0A", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        do_load(8'h60, 8'h00);
        expect_v("inv_min60", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);

        // Minute borrow: 10:00 -> 09:59; load during RUN ignored
        do_load(8'h10, 8'h00);
        do_start();
        second();
        expect_v("tick_0959", 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
        do_load(8'h00, 8'h30);
        expect_v("load_in_run", 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);

        // start and pause together in RUN: pause wins
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        expect_v("pause_wins", 8'h09, 8'h59, 1'b0, 1'b0, 1'b0);

        // Seconds tens borrow: 00:10 -> 00:09
        do_load(8'h00, 8'h10);
        do_start();
        second();
        expect_v("tick_0009", 8'h00, 8'h09, 1'b1, 1'b0, 1'b0);
        pause = 1'b1; step(); pause = 1'b0;

        // Largest value 59:59
        do_load(8'h59, 8'h59);
        do_start();
        second();
        expect_v("tick_5958", 8'h59, 8'h58, 1'b1, 1'b0, 1'b0);
        pause = 1'b1; step(); pause = 1'b0;

        // Pause coincident with a tick, then start coincident with a tick
        do_load(8'h05, 8'h30);
        do_start();
        second();
        second();
        expect_v("two_ticks", 8'h05, 8'h28, 1'b1, 1'b0, 1'b0);
        pause = 1'b1;
        rise();
        pause = 1'b0;
        expect_v("pause_on_tick", 8'h05, 8'h28, 1'b0, 1'b0, 1'b0);
        fall();
        second();
        expect_v("paused_hold", 8'h05, 8'h28, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        rise();
        start = 1'b0;
        expect_v("start_on_tick", 8'h05, 8'h28, 1'b1, 1'b0, 1'b0);
        fall();
        second();
        expect_v("resume_0527", 8'h05, 8'h27, 1'b1, 1'b0, 1'b0);

        // Reset mid-RUN at 02:00
        pause = 1'b1; step(); pause = 1'b0;
        do_load(8'h02, 8'h00);
        do_start();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rst_mid_run", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        expect_v("rst_no_done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Random stimulus against the model
        half = 2;
        cnt  = 0;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                min_in = 8'($urandom);
                sec_in = 8'($urandom);
            end else begin
                min_in = int2bcd(int'($urandom_range(0, 1)));
                sec_in = int2bcd(int'($urandom_range(0, 59)));
            end
            cnt++;
            if (cnt >= half) begin
                clk_1 = ~clk_1;
                cnt   = 0;
                half  = int'($urandom_range(1, 4));
            end
            step();
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
